// File: rtl/coco_keymatrix_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coco_keymatrix_if : ps2_key / PIA keyboard port bundle for coco_keymatrix |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface coco_keymatrix_if #(
  parameter int ROWS = 7,
  parameter int COLS = 8
);
  logic [10:0]     ps2_key;
  logic            clear_all;
  logic [COLS-1:0] col_n;
  logic [ROWS-1:0] row_n;
  logic            key_any;
  logic            unmapped;

  modport master (output ps2_key, clear_all, col_n, input row_n, key_any, unmapped);
  modport slave  (input ps2_key, clear_all, col_n, output row_n, key_any, unmapped);
endinterface
`default_nettype wire

// File: rtl/coco_keymatrix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | coco_keymatrix : ps2_key events -> CoCo 7x8 matrix, PIA row return        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module coco_keymatrix #(
  parameter int ROWS  = 7,
  parameter int COLS  = 8,
  parameter int CNT_W = 3
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  coco_keymatrix_if.slave   bus
);

  localparam int                 SHIFT_ROW = 6;
  localparam int                 SHIFT_COL = 7;
  localparam logic [1:0]         MOD_NONE  = 2'b00;
  localparam logic [1:0]         MOD_FORCE = 2'b01;
  localparam logic [1:0]         MOD_SUPP  = 2'b10;
  localparam logic [1:0]         SEL_NONE  = 2'b00;
  localparam logic [1:0]         SEL_LSH   = 2'b01;
  localparam logic [1:0]         SEL_RSH   = 2'b10;
  localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  // S1: toggle detect
  logic       init_q, init_d;
  logic       tog_q, tog_d;
  logic       s1_vld_q, s1_vld_d;
  logic       s1_pr_q, s1_pr_d;
  logic       s1_ext_q, s1_ext_d;
  logic [7:0] s1_code_q, s1_code_d;

  // S2: lookup result
  logic       s2_vld_q, s2_vld_d;
  logic       s2_pr_q, s2_pr_d;
  logic       s2_hit_q, s2_hit_d;
  logic [2:0] s2_row_q, s2_row_d;
  logic [2:0] s2_col_q, s2_col_d;
  logic [1:0] s2_mod_q, s2_mod_d;
  logic [1:0] s2_sel_q, s2_sel_d;

  // S3: matrix state
  logic [ROWS-1:0][COLS-1:0] key_q, key_d;
  logic                      lshift_q, lshift_d;
  logic                      rshift_q, rshift_d;
  logic [CNT_W-1:0]          fcnt_q, fcnt_d;
  logic [CNT_W-1:0]          scnt_q, scnt_d;
  logic                      unmapped_q, unmapped_d;

  // Output registers
  logic [ROWS-1:0]           row_n_q, row_n_d;
  logic                      key_any_q, key_any_d;

  logic                      lk_hit;
  logic [5:0]                lk_rc;
  logic [1:0]                lk_mod;
  logic [1:0]                lk_sel;
  logic                      held;
  logic                      shift_eff;
  logic [ROWS-1:0][COLS-1:0] mat;

  always_comb begin
    init_d    = 1'b1;
    tog_d     = tog_q;
    s1_vld_d  = 1'b0;
    s1_pr_d   = s1_pr_q;
    s1_ext_d  = s1_ext_q;
    s1_code_d = s1_code_q;
    // First clock out of reset only learns the toggle phase.
    if (!init_q) begin
      tog_d = bus.ps2_key[10];
    end else if (bus.ps2_key[10] != tog_q) begin
      tog_d     = bus.ps2_key[10];
      s1_vld_d  = ~bus.clear_all;
      s1_pr_d   = bus.ps2_key[9];
      s1_ext_d  = bus.ps2_key[8];
      s1_code_d = bus.ps2_key[7:0];
    end
  end

  // Scan code table; lk_rc is {row,col} written in octal.
  always_comb begin
    lk_hit = 1'b1;
    lk_rc  = 6'o00;
    lk_mod = MOD_NONE;
    lk_sel = SEL_NONE;
    if (s1_ext_q) begin
      case (s1_code_q)
        8'h75:   lk_rc = 6'o33;
        8'h72:   lk_rc = 6'o34;
        8'h6B:   lk_rc = 6'o35;
        8'h74:   lk_rc = 6'o36;
        8'h6C:   lk_rc = 6'o61;
        8'h5A:   lk_rc = 6'o60;
        default: lk_hit = 1'b0;
      endcase
    end else begin
      case (s1_code_q)
        8'h0E: lk_rc = 6'o00;  8'h1C: lk_rc = 6'o01;  8'h32: lk_rc = 6'o02;
        8'h21: lk_rc = 6'o03;  8'h23: lk_rc = 6'o04;  8'h24: lk_rc = 6'o05;
        8'h2B: lk_rc = 6'o06;  8'h34: lk_rc = 6'o07;
        8'h33: lk_rc = 6'o10;  8'h43: lk_rc = 6'o11;  8'h3B: lk_rc = 6'o12;
        8'h42: lk_rc = 6'o13;  8'h4B: lk_rc = 6'o14;  8'h3A: lk_rc = 6'o15;
        8'h31: lk_rc = 6'o16;  8'h44: lk_rc = 6'o17;
        8'h4D: lk_rc = 6'o20;  8'h15: lk_rc = 6'o21;  8'h2D: lk_rc = 6'o22;
        8'h1B: lk_rc = 6'o23;  8'h2C: lk_rc = 6'o24;  8'h3C: lk_rc = 6'o25;
        8'h2A: lk_rc = 6'o26;  8'h1D: lk_rc = 6'o27;
        8'h22: lk_rc = 6'o30;  8'h35: lk_rc = 6'o31;  8'h1A: lk_rc = 6'o32;
        8'h66: lk_rc = 6'o35;  8'h29: lk_rc = 6'o37;
        8'h45: lk_rc = 6'o40;  8'h16: lk_rc = 6'o41;  8'h1E: lk_rc = 6'o42;
        8'h26: lk_rc = 6'o43;  8'h25: lk_rc = 6'o44;  8'h2E: lk_rc = 6'o45;
        8'h36: lk_rc = 6'o46;  8'h3D: lk_rc = 6'o47;
        8'h52: begin lk_rc = 6'o47; lk_mod = MOD_FORCE; end
        8'h3E: lk_rc = 6'o50;  8'h46: lk_rc = 6'o51;
        8'h4C: begin lk_rc = 6'o52; lk_mod = MOD_SUPP;  end
        8'h41: lk_rc = 6'o54;  8'h4E: lk_rc = 6'o55;
        8'h55: begin lk_rc = 6'o55; lk_mod = MOD_FORCE; end
        8'h49: lk_rc = 6'o56;  8'h4A: lk_rc = 6'o57;
        8'h5A: lk_rc = 6'o60;  8'h76: lk_rc = 6'o62;
        8'h12: begin lk_rc = 6'o67; lk_sel = SEL_LSH;   end
        8'h59: begin lk_rc = 6'o67; lk_sel = SEL_RSH;   end
        default: lk_hit = 1'b0;
      endcase
    end
  end

  always_comb begin
    s2_vld_d = s1_vld_q & ~bus.clear_all;
    s2_pr_d  = s1_pr_q;
    s2_hit_d = lk_hit;
    s2_row_d = lk_rc[5:3];
    s2_col_d = lk_rc[2:0];
    s2_mod_d = lk_mod;
    s2_sel_d = lk_sel;
  end

  // Counts move only on real press/release transitions, so typematic
  // repeats and stray releases leave the shift overrides untouched.
  always_comb begin
    key_d      = key_q;
    lshift_d   = lshift_q;
    rshift_d   = rshift_q;
    fcnt_d     = fcnt_q;
    scnt_d     = scnt_q;
    unmapped_d = 1'b0;
    held       = key_q[s2_row_q][s2_col_q];
    if (bus.clear_all) begin
      key_d    = '0;
      lshift_d = 1'b0;
      rshift_d = 1'b0;
      fcnt_d   = '0;
      scnt_d   = '0;
    end else if (s2_vld_q) begin
      if (!s2_hit_q) begin
        unmapped_d = s2_pr_q;
      end else if (s2_sel_q == SEL_LSH) begin
        lshift_d = s2_pr_q;
      end else if (s2_sel_q == SEL_RSH) begin
        rshift_d = s2_pr_q;
      end else if (s2_pr_q != held) begin
        key_d[s2_row_q][s2_col_q] = s2_pr_q;
        if (s2_mod_q == MOD_FORCE) begin
          if (s2_pr_q && fcnt_q != CNT_MAX)     fcnt_d = fcnt_q + CNT_ONE;
          else if (!s2_pr_q && fcnt_q != '0)    fcnt_d = fcnt_q - CNT_ONE;
        end else if (s2_mod_q == MOD_SUPP) begin
          if (s2_pr_q && scnt_q != CNT_MAX)     scnt_d = scnt_q + CNT_ONE;
          else if (!s2_pr_q && scnt_q != '0)    scnt_d = scnt_q - CNT_ONE;
        end
      end
    end
  end

  assign shift_eff = (lshift_q | rshift_q | (fcnt_q != '0)) &
                     ~((scnt_q != '0) & (fcnt_q == '0));

  always_comb begin
    mat                       = key_q;
    mat[SHIFT_ROW][SHIFT_COL] = shift_eff;
    for (int r = 0; r < ROWS; r++) begin
      row_n_d[r] = ~|(mat[r] & ~bus.col_n);
    end
    key_any_d = |mat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_q     <= 1'b0;
      tog_q      <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_pr_q    <= 1'b0;
      s1_ext_q   <= 1'b0;
      s1_code_q  <= '0;
      s2_vld_q   <= 1'b0;
      s2_pr_q    <= 1'b0;
      s2_hit_q   <= 1'b0;
      s2_row_q   <= '0;
      s2_col_q   <= '0;
      s2_mod_q   <= MOD_NONE;
      s2_sel_q   <= SEL_NONE;
      key_q      <= '0;
      lshift_q   <= 1'b0;
      rshift_q   <= 1'b0;
      fcnt_q     <= '0;
      scnt_q     <= '0;
      unmapped_q <= 1'b0;
      row_n_q    <= '1;
      key_any_q  <= 1'b0;
    end else begin
      init_q     <= init_d;
      tog_q      <= tog_d;
      s1_vld_q   <= s1_vld_d;
      s1_pr_q    <= s1_pr_d;
      s1_ext_q   <= s1_ext_d;
      s1_code_q  <= s1_code_d;
      s2_vld_q   <= s2_vld_d;
      s2_pr_q    <= s2_pr_d;
      s2_hit_q   <= s2_hit_d;
      s2_row_q   <= s2_row_d;
      s2_col_q   <= s2_col_d;
      s2_mod_q   <= s2_mod_d;
      s2_sel_q   <= s2_sel_d;
      key_q      <= key_d;
      lshift_q   <= lshift_d;
      rshift_q   <= rshift_d;
      fcnt_q     <= fcnt_d;
      scnt_q     <= scnt_d;
      unmapped_q <= unmapped_d;
      row_n_q    <= row_n_d;
      key_any_q  <= key_any_d;
    end
  end

  assign bus.row_n    = row_n_q;
  assign bus.key_any  = key_any_q;
  assign bus.unmapped = unmapped_q;

endmodule
`default_nettype wire

// File: tb/tb_coco_keymatrix.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_coco_keymatrix : scoreboard bench with a keyboard-level reference model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_coco_keymatrix;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  coco_keymatrix_if kif ();

  coco_keymatrix #(.ROWS(7), .COLS(8), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (kif.slave)
  );

  typedef struct { int r; int c; int m; } ent_t;   // m: 0 none,1 force,2 supp,4 lsh,5 rsh
  typedef struct { string nm; logic [6:0] rn; logic ka; int unm; } exp_t;

  ent_t tbl[int];
  int   pool[$];
  exp_t exp_q[$];

  bit held[7][8];
  bit lsh, rsh;
  int fcnt, scnt;
  bit tog;
  bit sample_req = 1'b0;
  int unm_seen = 0;
  int n_chk = 0;
  int n_pass = 0;

  task automatic add(input int k, input int r, input int c, input int m);
    tbl[k] = '{r, c, m};
    pool.push_back(k);
  endtask

  function automatic void model_clear();
    for (int r = 0; r < 7; r++) for (int c = 0; c < 8; c++) held[r][c] = 1'b0;
    lsh = 0; rsh = 0; fcnt = 0; scnt = 0;
  endfunction

  function automatic int model_event(input bit pr, input int k);
    ent_t e;
    if (!tbl.exists(k)) return pr ? 1 : 0;
    e = tbl[k];
    if (e.m == 4) lsh = pr;
    else if (e.m == 5) rsh = pr;
    else if (held[e.r][e.c] != pr) begin
      held[e.r][e.c] = pr;
      if (e.m == 1) fcnt = pr ? ((fcnt < 7) ? fcnt + 1 : 7) : ((fcnt > 0) ? fcnt - 1 : 0);
      if (e.m == 2) scnt = pr ? ((scnt < 7) ? scnt + 1 : 7) : ((scnt > 0) ? scnt - 1 : 0);
    end
    return 0;
  endfunction

  function automatic void expect_out(input logic [7:0] coln, output logic [6:0] rn, output logic ka);
    bit eff, h;
    eff = (lsh || rsh || fcnt != 0) && !(scnt != 0 && fcnt == 0);
    rn = 7'h7F;
    ka = 1'b0;
    for (int r = 0; r < 7; r++) begin
      for (int c = 0; c < 8; c++) begin
        h = (r == 6 && c == 7) ? eff : held[r][c];
        if (h) ka = 1'b1;
        if (h && !coln[c]) rn[r] = 1'b0;
      end
    end
  endfunction

  task automatic push_exp(input string nm, input int unm);
    logic [6:0] rn;
    logic ka;
    expect_out(kif.col_n, rn, ka);
    exp_q.push_back('{nm, rn, ka, unm});
  endtask

  task automatic pulse_sample();
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
  endtask

  task automatic op(input bit ev, input bit pr, input bit ext, input logic [7:0] code,
                    input bit clr, input logic [7:0] coln, input string nm);
    int unm;
    @(negedge clk);
    unm = 0;
    if (ev) begin
      tog = ~tog;
      kif.ps2_key = {tog, pr, ext, code};
    end
    kif.clear_all = clr;
    kif.col_n     = coln;
    if (clr) model_clear();
    else if (ev) unm = model_event(pr, (ext ? 256 : 0) + int'(code));
    push_exp(nm, unm);
    @(negedge clk);
    kif.clear_all = 1'b0;
    repeat (4) @(negedge clk);
    pulse_sample();
  endtask

  // Monitor: counts unmapped pulses and scores outputs when a sample is due.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (kif.unmapped) unm_seen++;
      if (sample_req) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL scoreboard_empty: sample with no expectation queued");
        end else begin
          e = exp_q.pop_front();
          n_chk++;
          if (kif.row_n === e.rn) n_pass++;
          else $display("FAIL %s row_n: got %h want %h", e.nm, kif.row_n, e.rn);
          n_chk++;
          if (kif.key_any === e.ka) n_pass++;
          else $display("FAIL %s key_any: got %b want %b", e.nm, kif.key_any, e.ka);
          n_chk++;
          if (unm_seen == e.unm) n_pass++;
          else $display("FAIL %s unmapped_cycles: got %0d want %0d", e.nm, unm_seen, e.unm);
        end
        unm_seen = 0;
      end
    end
  end

  initial begin
    int k;
    bit pr, clr;
    logic [7:0] coln;
    // Reference keyboard table (set-2 scan codes; ext codes offset by 256)
    add('h0E,0,0,0); add('h1C,0,1,0); add('h32,0,2,0); add('h21,0,3,0);
    add('h23,0,4,0); add('h24,0,5,0); add('h2B,0,6,0); add('h34,0,7,0);
    add('h33,1,0,0); add('h43,1,1,0); add('h3B,1,2,0); add('h42,1,3,0);
    add('h4B,1,4,0); add('h3A,1,5,0); add('h31,1,6,0); add('h44,1,7,0);
    add('h4D,2,0,0); add('h15,2,1,0); add('h2D,2,2,0); add('h1B,2,3,0);
    add('h2C,2,4,0); add('h3C,2,5,0); add('h2A,2,6,0); add('h1D,2,7,0);
    add('h22,3,0,0); add('h35,3,1,0); add('h1A,3,2,0); add('h66,3,5,0); add('h29,3,7,0);
    add('h45,4,0,0); add('h16,4,1,0); add('h1E,4,2,0); add('h26,4,3,0);
    add('h25,4,4,0); add('h2E,4,5,0); add('h36,4,6,0); add('h3D,4,7,0); add('h52,4,7,1);
    add('h3E,5,0,0); add('h46,5,1,0); add('h4C,5,2,2); add('h41,5,4,0);
    add('h4E,5,5,0); add('h55,5,5,1); add('h49,5,6,0); add('h4A,5,7,0);
    add('h5A,6,0,0); add('h76,6,2,0); add('h12,6,7,4); add('h59,6,7,5);
    add(256+'h75,3,3,0); add(256+'h72,3,4,0); add(256+'h6B,3,5,0); add(256+'h74,3,6,0);
    add(256+'h6C,6,1,0); add(256+'h5A,6,0,0);
    pool.push_back('h07); pool.push_back('h05); pool.push_back(256+'h12); pool.push_back('h0D);

    model_clear();
    tog = 1'b1;
    kif.ps2_key   = {1'b1, 10'h000};
    kif.clear_all = 1'b0;
    kif.col_n     = 8'h00;
    repeat (3) @(negedge clk);
    push_exp("reset", 0);
    pulse_sample();
    rst_n = 1'b1;

    op(1,1,0,8'h1C,0,8'hFD,"A_press");
    op(0,0,0,8'h00,0,8'hFE,"A_col0");
    op(1,0,0,8'h1C,0,8'hFD,"A_release");
    op(1,1,0,8'h55,0,8'h7F,"eq_force_shift");
    op(0,0,0,8'h00,0,8'hDF,"eq_minus");
    op(1,0,0,8'h55,0,8'h5F,"eq_release");
    op(1,1,0,8'h12,0,8'h7F,"lshift_press");
    op(1,1,0,8'h4C,0,8'h7F,"semi_suppress");
    op(0,0,0,8'h00,0,8'hFB,"colon_held");
    op(1,0,0,8'h4C,0,8'h7F,"semi_release");
    op(1,0,0,8'h12,0,8'h7F,"lshift_release");
    for (int i = 0; i < 10; i++) op(1,1,0,8'h55,0,8'h7F,"typematic");
    op(1,0,0,8'h55,0,8'h00,"typematic_release");
    op(1,1,0,8'h1C,0,8'hFD,"hold_A");
    op(1,1,0,8'h15,0,8'hFD,"hold_Q");
    op(1,1,0,8'h1A,1,8'h00,"clear_with_Z");
    op(0,0,0,8'h00,0,8'h00,"after_clear");
    op(1,1,1,8'h75,0,8'hF7,"ext_up");
    op(1,1,0,8'h07,0,8'hFF,"unmapped_press");
    op(1,0,0,8'h07,0,8'hFF,"unmapped_release");
    op(1,0,1,8'h75,0,8'h00,"ext_up_release");

    for (int i = 0; i < 300; i++) begin
      k    = pool[$urandom_range(pool.size() - 1)];
      pr   = ($urandom_range(9) < 6);
      clr  = ($urandom_range(24) == 0);
      coln = $urandom_range(1) ? ~(8'h01 << $urandom_range(7)) : 8'($urandom);
      op($urandom_range(7) != 0, pr, k >= 256, 8'(k), clr, coln, "random");
    end

    // Reset with an 'A' press still in the pipeline
    op(1,0,0,8'h00,1,8'hFF,"pre_reset_clear");
    @(negedge clk);
    tog = ~tog;
    kif.ps2_key = {tog, 1'b1, 1'b0, 8'h1C};
    kif.col_n   = 8'hFD;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    op(0,0,0,8'h00,0,8'hFD,"reset_flush");

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
